// File: rtl/intel_vip_reset_sequencer.sv
// intel_vip_reset_sequencer
// Holds every downstream reset domain for a minimum time once the subsystem
// reset drops and the PLL is locked. It then releases the domains one at a
// time, in index order, with a fixed gap between releases. A PLL lock loss
// (once releasing has begun) or a software request restarts the sequence.
module intel_vip_reset_sequencer #(
  parameter int NUM_OUTPUTS        = 4,
  parameter int MIN_ASSERT_CYCLES  = 16,
  parameter int RELEASE_GAP_CYCLES = 8,
  parameter int LOCK_SYNC_DEPTH    = 3,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   pll_locked_in,
  input  logic                   sw_reset_req,
  output logic [NUM_OUTPUTS-1:0] reset_out,
  output logic                   reset_done,
  output logic [1:0]             seq_state
);

  // One extra index bit, so the index can step past the last output.
  localparam int IDX_W = $clog2(NUM_OUTPUTS + 1);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t                     state_reg;
  logic [CNT_WIDTH-1:0]       cnt_reg;
  logic [IDX_W-1:0]           idx_reg;
  // Each domain reset fans out on local routing. Keep these flops off the
  // global clock/reset network so that bit-to-bit release timing holds.
  (* altera_attribute = "-name GLOBAL_SIGNAL OFF" *)
  logic [NUM_OUTPUTS-1:0]     reset_out_reg;
  logic                       reset_done_reg;
  logic [LOCK_SYNC_DEPTH-1:0] lock_sync_reg;

  logic lock_s;
  logic restart;
  logic assert_tc;
  logic release_tc;
  logic release_now;
  logic last_bit;

  assign lock_s = lock_sync_reg[LOCK_SYNC_DEPTH-1];

  // Lock loss only restarts the sequence once releasing has begun. While
  // the domains are still held in ASSERT, lock is checked only at terminal
  // count.
  assign restart = sw_reset_req |
                   (~lock_s & ((state_reg == ST_RELEASE) | (state_reg == ST_DONE)));

  assign assert_tc  = (state_reg == ST_ASSERT) &&
                      (cnt_reg == CNT_WIDTH'(MIN_ASSERT_CYCLES - 1));
  assign release_tc = (state_reg == ST_RELEASE) &&
                      (cnt_reg == CNT_WIDTH'(RELEASE_GAP_CYCLES - 1));

  // The first release (out of ASSERT or WAIT_LOCK) and every later gap
  // release do the same work: drop the next bit and restart the gap counter.
  assign release_now = (assert_tc & lock_s) |
                       ((state_reg == ST_WAIT_LOCK) & lock_s) |
                       release_tc;
  assign last_bit    = (idx_reg == IDX_W'(NUM_OUTPUTS - 1));

  // Bring the asynchronous PLL lock into the clk_in domain through a flop chain.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      lock_sync_reg <= '0;
    end else begin
      lock_sync_reg <= {lock_sync_reg[LOCK_SYNC_DEPTH-2:0], pll_locked_in};
    end
  end

  // Sequencer FSM. Every output is driven directly from a register here.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg      <= ST_ASSERT;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      reset_out_reg  <= '1;
      reset_done_reg <= 1'b0;
    end else if (restart) begin
      state_reg      <= ST_ASSERT;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      reset_out_reg  <= '1;
      reset_done_reg <= 1'b0;
    end else if (release_now) begin
      // Released bits form a contiguous low run, so a left shift clears
      // exactly bit idx_reg.
      reset_out_reg <= reset_out_reg << 1;
      idx_reg       <= idx_reg + IDX_W'(1);
      cnt_reg       <= '0;
      if (last_bit) begin
        state_reg      <= ST_DONE;
        reset_done_reg <= 1'b1;
      end else begin
        state_reg <= ST_RELEASE;
      end
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          if (assert_tc) begin
            state_reg <= ST_WAIT_LOCK;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          end
        end
        ST_RELEASE: begin
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
        default: begin
          // WAIT_LOCK and DONE hold with the counter idle.
          cnt_reg <= cnt_reg;
        end
      endcase
    end
  end

  assign reset_out  = reset_out_reg;
  assign reset_done = reset_done_reg;
  assign seq_state  = state_reg;

endmodule
